spi_sensor_resp: RTL

SPI_SENSOR_RESP -- requirements
Module: spi_sensor_resp

---
 rtl/spi_resp_pkg.sv | 13 +
 rtl/spi_sensor_resp_if.sv | 13 +
 rtl/spi_edge_sync.sv | 42 ++++
 rtl/spi_sensor_resp.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI sensor responder.
package spi_resp_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam logic [ADDR_W-1:0] WHO_AM_I_ADDR = 6'h0F;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

endpackage

// File: rtl/spi_sensor_resp_if.sv
// SPI pin bundle between initiator (master) and responder (slave).
interface spi_sensor_resp_if;

    logic spc;
    logic cs;
    logic sdi;
    logic sdo;
    logic sdo_oe;

    modport master (output spc, output cs, output sdi, input sdo, input sdo_oe);
    modport slave  (input spc, input cs, input sdi, output sdo, output sdo_oe);

endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with rise/fall pulse detection in the clk domain.
module spi_edge_sync
    import spi_resp_pkg::*;
#(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   flush_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= {STAGES{RST_VAL}};
            prev_q  <= RST_VAL;
            flush_q <= '0;
        end else begin
            sync_q[0]  <= din;
            flush_q[0] <= 1'b1;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            for (int unsigned i = 1; i <= STAGES; i++) begin
                flush_q[i] <= flush_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Edges are only reported once both compared values are real post-reset
    // samples, so a level held through reset never looks like a fresh edge.
    assign rise = flush_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
    assign fall = flush_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_sensor_resp.sv
// SPI mode-3 sensor responder: 64x8 register file with SPI and host access.
module spi_sensor_resp
    import spi_resp_pkg::*;
#(
    parameter logic [7:0]  WHO_AM_I    = 8'h33,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    spi_sensor_resp_if.slave  spi,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    input  logic [ADDR_W-1:0] host_raddr,
    output logic [7:0]        host_rdata,
    output logic              spi_wr,
    output logic [ADDR_W-1:0] spi_wr_addr,
    output logic [7:0]        spi_wr_data
);

    logic spc_rise, spc_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] sdi_q;
    logic sdi_s;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_spc_sync (
        .clk  (clk),
        .rstn (rstn),
        .din  (spi.spc),
        .rise (spc_rise),
        .fall (spc_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rstn (rstn),
        .din  (spi.cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sdi_q <= '0;
        end else begin
            sdi_q[0] <= spi.sdi;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sdi_q[i] <= sdi_q[i-1];
            end
        end
    end
    assign sdi_s = sdi_q[SYNC_STAGES-1];

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q;
    logic [6:0]        shift_in_q;
    logic [7:0]        shift_out_q;
    logic              sdo_q;
    logic              rw_q, ms_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        mem_q [64];

    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] next_addr;
    logic              byte_done, cmd_done, data_done, wr_commit;

    function automatic logic [7:0] reg_rd(input logic [ADDR_W-1:0] a);
        return (a == WHO_AM_I_ADDR) ? WHO_AM_I : mem_q[a];
    endfunction

    // The 8th bit is taken straight from the synchronizer, so only seven bits are stored.
    assign rx_byte   = {shift_in_q, sdi_s};
    assign byte_done = spc_rise && (bit_cnt_q == 3'd7);
    assign cmd_done  = (state_q == CMD)  && byte_done && !cs_rise;
    assign data_done = (state_q == DATA) && byte_done && !cs_rise;
    assign wr_commit = data_done && !rw_q && (addr_q != WHO_AM_I_ADDR);
    assign next_addr = ms_q ? addr_q + 6'd1 : addr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = CMD;
            CMD:     if (cs_rise) state_d = IDLE;
                     else if (byte_done) state_d = DATA;
            DATA:    if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            sdo_q       <= 1'b0;
            rw_q        <= 1'b0;
            ms_q        <= 1'b0;
            addr_q      <= '0;
            spi_wr      <= 1'b0;
            spi_wr_addr <= '0;
            spi_wr_data <= '0;
        end else begin
            spi_wr <= 1'b0;
            if (state_q == IDLE) begin
                bit_cnt_q <= '0;
                sdo_q     <= 1'b0;
            end else if (spc_rise) begin
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                shift_in_q <= rx_byte[6:0];
            end
            if (cmd_done) begin
                rw_q   <= rx_byte[7];
                ms_q   <= rx_byte[6];
                addr_q <= rx_byte[5:0];
                if (rx_byte[7]) shift_out_q <= reg_rd(rx_byte[5:0]);
            end
            if (data_done) begin
                addr_q <= next_addr;
                if (rw_q) shift_out_q <= reg_rd(next_addr);
            end
            if (wr_commit) begin
                spi_wr      <= 1'b1;
                spi_wr_addr <= addr_q;
                spi_wr_data <= rx_byte;
            end
            if ((state_q == DATA) && rw_q && spc_fall && !cs_rise) begin
                sdo_q       <= shift_out_q[7];
                shift_out_q <= {shift_out_q[6:0], 1'b0};
            end
        end
    end

    // SPI commit is applied after the host write so it wins on an address clash.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q      <= '{default: '0};
            host_rdata <= '0;
        end else begin
            if (host_we && (host_addr != WHO_AM_I_ADDR)) mem_q[host_addr] <= host_wdata;
            if (wr_commit) mem_q[addr_q] <= rx_byte;
            host_rdata <= reg_rd(host_raddr);
        end
    end

    // DATA is only ever left through a cs rising edge, so inside DATA the
    // synchronized cs is low in every cycle except the one flagging cs_rise.
    assign spi.sdo_oe = (state_q == DATA) && rw_q && !cs_rise;
    assign spi.sdo    = spi.sdo_oe & sdo_q;

endmodule
